// File: rtl/pipelined_prefix_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_prefix_adder
// Brief    : 3-stage Kogge-Stone adder/subtractor with valid/ready flow control
//            and signed-overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_prefix_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] operand1_i,
    input  logic [WIDTH-1:0] operand2_i,
    input  logic             carry_i,
    input  logic             sub_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             valid_o,
    input  logic             ready_i
);

    localparam int c_levels = $clog2(WIDTH + 1);

    // Stage load enables, chained back from the output so bubbles collapse
    logic w_ld1, w_ld2, w_ld3;

    logic [WIDTH-1:0] w_b;
    logic             w_cin;

    logic [WIDTH:0]   r_p1, r_g1;
    logic             r_amsb1, r_bmsb1, r_v1;

    logic [WIDTH:0]   w_gg;
    logic [WIDTH:0]   r_p2, r_gg2;
    logic             r_amsb2, r_bmsb2, r_v2;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry, r_ovf, r_v3;

    assign w_ld3   = !r_v3 || ready_i;
    assign w_ld2   = !r_v2 || w_ld3;
    assign w_ld1   = !r_v1 || w_ld2;
    assign ready_o = w_ld1;

    // Subtraction as a + ~b + ~borrow
    assign w_b   = sub_i ? ~operand2_i : operand2_i;
    assign w_cin = sub_i ^ carry_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_p1    <= '0;
            r_g1    <= '0;
            r_amsb1 <= 1'b0;
            r_bmsb1 <= 1'b0;
            r_v1    <= 1'b0;
        end else if (w_ld1) begin
            r_p1    <= {operand1_i ^ w_b, 1'b0};
            r_g1    <= {operand1_i & w_b, w_cin};
            r_amsb1 <= operand1_i[WIDTH-1];
            r_bmsb1 <= w_b[WIDTH-1];
            r_v1    <= valid_i;
        end
    end

    // In-place prefix combine; descending index keeps lower-level values intact
    always_comb begin
        logic [WIDTH:0] v_g;
        logic [WIDTH:0] v_p;
        v_g = r_g1;
        v_p = r_p1;
        for (int k = 0; k < c_levels; k++) begin
            for (int i = WIDTH; i >= (1 << k); i--) begin
                v_g[i] = v_g[i] | (v_p[i] & v_g[i - (1 << k)]);
                v_p[i] = v_p[i] & v_p[i - (1 << k)];
            end
        end
        w_gg = v_g;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_p2    <= '0;
            r_gg2   <= '0;
            r_amsb2 <= 1'b0;
            r_bmsb2 <= 1'b0;
            r_v2    <= 1'b0;
        end else if (w_ld2) begin
            r_p2    <= r_p1;
            r_gg2   <= w_gg;
            r_amsb2 <= r_amsb1;
            r_bmsb2 <= r_bmsb1;
            r_v2    <= r_v1;
        end
    end

    assign w_sum = r_p2[WIDTH:1] ^ r_gg2[WIDTH-1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_v3    <= 1'b0;
        end else if (w_ld3) begin
            r_sum   <= w_sum;
            r_carry <= r_gg2[WIDTH];
            r_ovf   <= (r_amsb2 == r_bmsb2) && (w_sum[WIDTH-1] != r_amsb2);
            r_v3    <= r_v2;
        end
    end

    assign sum_o      = r_sum;
    assign carry_o    = r_carry;
    assign overflow_o = r_ovf;
    assign valid_o    = r_v3;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_prefix_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_prefix_adder
// Brief    : Scoreboard bench driving WIDTH=16, 8 and 13 instances in lockstep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_prefix_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] op1 = '0, op2 = '0;
    logic        cin = 1'b0, sub = 1'b0, vin = 1'b0, rdy_in = 1'b0;

    logic        rdy16, co16, ov16, vo16;
    logic [15:0] s16;
    logic        rdy8, co8, ov8, vo8;
    logic [7:0]  s8;
    logic        rdy13, co13, ov13, vo13;
    logic [12:0] s13;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit chk_lat = 1'b0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic        s;
        int          cyc;
    } beat_t;

    beat_t q16[$], q8[$], q13[$];

    always #5 clk = ~clk;

    pipelined_prefix_adder #(.WIDTH(16)) u_dut16 (
        .clk_i(clk), .rst_i(rst), .operand1_i(op1), .operand2_i(op2),
        .carry_i(cin), .sub_i(sub), .valid_i(vin), .ready_o(rdy16),
        .sum_o(s16), .carry_o(co16), .overflow_o(ov16), .valid_o(vo16),
        .ready_i(rdy_in));

    pipelined_prefix_adder #(.WIDTH(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .operand1_i(op1[7:0]), .operand2_i(op2[7:0]),
        .carry_i(cin), .sub_i(sub), .valid_i(vin), .ready_o(rdy8),
        .sum_o(s8), .carry_o(co8), .overflow_o(ov8), .valid_o(vo8),
        .ready_i(rdy_in));

    pipelined_prefix_adder #(.WIDTH(13)) u_dut13 (
        .clk_i(clk), .rst_i(rst), .operand1_i(op1[12:0]), .operand2_i(op2[12:0]),
        .carry_i(cin), .sub_i(sub), .valid_i(vin), .ready_o(rdy13),
        .sum_o(s13), .carry_o(co13), .overflow_o(ov13), .valid_o(vo13),
        .ready_i(rdy_in));

    // Behavioural reference: returns {overflow, carry, sum zero-extended to 16}
    function automatic logic [17:0] model(input int w, input logic [15:0] a,
                                          input logic [15:0] b, input logic c,
                                          input logic s);
        logic [31:0] mask, aa, bb, full, sm;
        logic        ci, am, bm;
        mask = (32'd1 << w) - 32'd1;
        aa   = {16'h0, a} & mask;
        bb   = (s ? {16'h0, ~b} : {16'h0, b}) & mask;
        ci   = s ^ c;
        full = aa + bb + {31'd0, ci};
        sm   = full & mask;
        am   = aa[w-1];
        bm   = bb[w-1];
        return {(am == bm) && (sm[w-1] != am), full[w], sm[15:0]};
    endfunction

    // Scoreboard: push on accept, pop and compare on delivery
    beat_t       bt;
    logic [17:0] exp_v, act_v;
    always @(negedge clk) begin
        #4;
        cyc++;
        if (!rst) begin
            if (vin && rdy16) q16.push_back('{op1, op2, cin, sub, cyc});
            if (vin && rdy8)  q8.push_back('{op1, op2, cin, sub, cyc});
            if (vin && rdy13) q13.push_back('{op1, op2, cin, sub, cyc});

            if (vo16 && rdy_in) begin
                checks++;
                act_v = {ov16, co16, s16};
                if (q16.size() == 0) begin
                    errors++;
                    $display("FAIL out16_extra: got %h, expected no beat", act_v);
                end else begin
                    bt    = q16.pop_front();
                    exp_v = model(16, bt.a, bt.b, bt.c, bt.s);
                    if (act_v !== exp_v) begin
                        errors++;
                        $display("FAIL out16: got %h, expected %h", act_v, exp_v);
                    end
                    if (chk_lat) begin
                        checks++;
                        if (cyc - bt.cyc != 3) begin
                            errors++;
                            $display("FAIL lat16: got %0d, expected 3", cyc - bt.cyc);
                        end
                    end
                end
            end
            if (vo8 && rdy_in) begin
                checks++;
                act_v = {ov8, co8, 8'h00, s8};
                if (q8.size() == 0) begin
                    errors++;
                    $display("FAIL out8_extra: got %h, expected no beat", act_v);
                end else begin
                    bt    = q8.pop_front();
                    exp_v = model(8, bt.a, bt.b, bt.c, bt.s);
                    if (act_v !== exp_v) begin
                        errors++;
                        $display("FAIL out8: got %h, expected %h", act_v, exp_v);
                    end
                end
            end
            if (vo13 && rdy_in) begin
                checks++;
                act_v = {ov13, co13, 3'b000, s13};
                if (q13.size() == 0) begin
                    errors++;
                    $display("FAIL out13_extra: got %h, expected no beat", act_v);
                end else begin
                    bt    = q13.pop_front();
                    exp_v = model(13, bt.a, bt.b, bt.c, bt.s);
                    if (act_v !== exp_v) begin
                        errors++;
                        $display("FAIL out13: got %h, expected %h", act_v, exp_v);
                    end
                    if (chk_lat) begin
                        checks++;
                        if (cyc - bt.cyc != 3) begin
                            errors++;
                            $display("FAIL lat13: got %0d, expected 3", cyc - bt.cyc);
                        end
                    end
                end
            end
        end
    end

    // One clock of stimulus; acc reports whether the 16-bit instance took it
    task automatic cycle_drive(input bit v, input logic [15:0] a, input logic [15:0] b,
                               input logic c, input logic s, input bit r, output bit acc);
        @(negedge clk);
        vin = v; op1 = a; op2 = b; cin = c; sub = s; rdy_in = r;
        #4;
        acc = vin && rdy16;
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 20 && (q16.size() + q8.size() + q13.size()) != 0; i++)
            cycle_drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc);
        checks++;
        if ((q16.size() + q8.size() + q13.size()) != 0) begin
            errors++;
            $display("FAIL drain: got %0d beats pending, expected 0",
                     q16.size() + q8.size() + q13.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if ({vo16, vo8, vo13, s16, s8, s13, co16, co8, co13, ov16, ov8, ov13} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b%b%b s=%h/%h/%h, expected all zero",
                     vo16, vo8, vo13, s16, s8, s13);
        end
        rst = 1'b0;
        #2;
        checks++;
        if ({rdy16, rdy8, rdy13} !== 3'b111) begin
            errors++;
            $display("FAIL reset_ready: got %b, expected 111", {rdy16, rdy8, rdy13});
        end
    endtask

    task automatic test_directed();
        logic [15:0] ta[4] = '{16'h00FF, 16'h007F, 16'h0080, 16'h0000};
        logic [15:0] tb[4] = '{16'h0001, 16'h0001, 16'h0001, 16'h0000};
        logic        tc[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic        ts[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [9:0]  te[4] = '{{1'b0, 1'b1, 8'h00}, {1'b1, 1'b0, 8'h80},
                               {1'b1, 1'b1, 8'h7F}, {1'b0, 1'b0, 8'hFF}};
        bit acc;
        bit seen;
        chk_lat = 1'b1;
        for (int n = 0; n < 4; n++) begin
            cycle_drive(1'b1, ta[n], tb[n], tc[n], ts[n], 1'b1, acc);
            seen = 1'b0;
            for (int t = 0; t < 6 && !seen; t++) begin
                cycle_drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc);
                seen = vo8;
            end
            checks++;
            if (!seen || {ov8, co8, s8} !== te[n]) begin
                errors++;
                $display("FAIL directed8_%0d: got v=%b %h, expected %h", n, seen,
                         {ov8, co8, s8}, te[n]);
            end
        end
        drain();
    endtask

    task automatic test_stream();
        bit acc;
        int missed = 0;
        chk_lat = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            cycle_drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom),
                        1'($urandom), 1'b1, acc);
            if (!acc) missed++;
        end
        checks++;
        if (missed != 0) begin
            errors++;
            $display("FAIL stream_rate: got %0d missed accepts, expected 0", missed);
        end
        drain();
    endtask

    task automatic test_backpressure();
        bit          acc;
        int          accepted = 0;
        logic [15:0] a, b;
        logic        c, s;
        logic [39:0] snap;
        chk_lat = 1'b0;
        a = 16'($urandom); b = 16'($urandom); c = 1'($urandom); s = 1'($urandom);
        for (int t = 0; t < 8; t++) begin
            cycle_drive(1'b1, a, b, c, s, 1'b0, acc);
            if (acc) begin
                accepted++;
                a = 16'($urandom); b = 16'($urandom); c = 1'($urandom); s = 1'($urandom);
            end
            if (t == 5) snap = {ov16, co16, s16, ov8, co8, s8, vo16, vo8, vo13};
            if (t > 5) begin
                checks++;
                if ({ov16, co16, s16, ov8, co8, s8, vo16, vo8, vo13} !== snap) begin
                    errors++;
                    $display("FAIL stall_stable: got %h, expected %h",
                             {ov16, co16, s16, ov8, co8, s8, vo16, vo8, vo13}, snap);
                end
            end
        end
        checks++;
        if (accepted != 3 || rdy16 !== 1'b0) begin
            errors++;
            $display("FAIL stall_accept: got %0d accepted ready=%b, expected 3 ready=0",
                     accepted, rdy16);
        end
        for (int n = 0; n < 300; n++) begin
            acc = 1'b0;
            for (int t = 0; t < 60 && !acc; t++)
                cycle_drive(1'b1, a, b, c, s, 1'($urandom), acc);
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL bp_accept: got no accept, expected accept within 60 cycles");
            end
            a = 16'($urandom); b = 16'($urandom); c = 1'($urandom); s = 1'($urandom);
            if ($urandom_range(0, 3) == 0)
                cycle_drive(1'b0, a, b, c, s, 1'($urandom), acc);
        end
        drain();
    endtask

    task automatic test_reset_inflight();
        bit acc;
        chk_lat = 1'b0;
        for (int t = 0; t < 3; t++)
            cycle_drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom),
                        1'($urandom), 1'b0, acc);
        @(negedge clk);
        vin = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({vo16, vo8, vo13, s16, s8, s13, co16, co8, co13, ov16, ov8, ov13} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got v=%b%b%b s=%h/%h/%h, expected all zero",
                     vo16, vo8, vo13, s16, s8, s13);
        end
        q16.delete();
        q8.delete();
        q13.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #2;
        checks++;
        if ({rdy16, rdy8, rdy13} !== 3'b111 || {vo16, vo8, vo13} !== 3'b000) begin
            errors++;
            $display("FAIL postreset_state: got ready=%b valid=%b, expected 111/000",
                     {rdy16, rdy8, rdy13}, {vo16, vo8, vo13});
        end
        chk_lat = 1'b1;
        cycle_drive(1'b1, 16'h1234, 16'h0FF1, 1'b1, 1'b1, 1'b1, acc);
        drain();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stream();
        test_backpressure();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
